// File: rtl/l2_cache_pkg.sv
// -----------------------------------------------------------------------------
// l2_cache_pkg
// Shared definitions for the L2 cache controller slice.
// Contents:
//   ADDR_W, DATA_W, OFFSET_BITS : bus widths and byte-offset width
//   l2_state_e                  : controller FSM states
//   get_index / get_tag         : address field extraction, sized by INDEX_BITS
// -----------------------------------------------------------------------------
package l2_cache_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 64;
  localparam int OFFSET_BITS = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RAS,
    MEM_CAS,
    RESPOND
  } l2_state_e;

  // Line index sits directly above the byte offset; callers truncate the
  // result to INDEX_BITS.
  function automatic logic [ADDR_W-1:0] get_index(input logic [ADDR_W-1:0] addr,
                                                  input int index_bits);
    return (addr >> OFFSET_BITS) & ((ADDR_W'(1) << index_bits) - ADDR_W'(1));
  endfunction

  // Tag is everything above the index; callers truncate to the tag width.
  function automatic logic [ADDR_W-1:0] get_tag(input logic [ADDR_W-1:0] addr,
                                                input int index_bits);
    return addr >> (OFFSET_BITS + index_bits);
  endfunction

endpackage

// File: rtl/l2_cache_test_if.sv
// -----------------------------------------------------------------------------
// l2_cache_test_if
// Handshake and memory-control signals between L1, the L2 controller and the
// main memory model. The two 64-bit data buses are bidirectional and travel
// as plain inout ports on the controller instead.
// Signals:
//   stb, we_in, addr_l1 : L1 request strobe, write flag, byte address
//   l1_ack              : one-cycle completion pulse back to L1
//   mem_addr            : word-aligned memory address
//   cs_n/ras_n/cas_n/we_n : active-low memory controls
//   stb_mem             : memory completion strobe
// Modports: master (L1 + memory side), slave (cache controller).
// -----------------------------------------------------------------------------
interface l2_cache_test_if;
  import l2_cache_pkg::*;

  logic              stb;
  logic              we_in;
  logic [ADDR_W-1:0] addr_l1;
  logic              l1_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              cs_n;
  logic              ras_n;
  logic              cas_n;
  logic              we_n;
  logic              stb_mem;

  modport master (
    output stb, we_in, addr_l1, stb_mem,
    input  l1_ack, mem_addr, cs_n, ras_n, cas_n, we_n
  );

  modport slave (
    input  stb, we_in, addr_l1, stb_mem,
    output l1_ack, mem_addr, cs_n, ras_n, cas_n, we_n
  );

endinterface

// File: rtl/l2_tag_data_array.sv
// -----------------------------------------------------------------------------
// l2_tag_data_array
// Direct-mapped line storage: one valid bit, tag and 64-bit word per line.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (clears valid bits)
//   rd_idx_i       : combinational read index
//   rd_valid_o/rd_tag_o/rd_data_o : contents of the addressed line
//   wr_en_i, wr_idx_i, wr_tag_i, wr_data_i : single write port; a write
//                    always marks the line valid
// -----------------------------------------------------------------------------
module l2_tag_data_array
  import l2_cache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_W      = ADDR_W - INDEX_BITS - OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [DATA_W-1:0]     rd_data_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic [DATA_W-1:0]     wr_data_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // Valid bits are the only state that needs reset; stale tag/data behind a
  // cleared valid bit is never observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/l2_cache_test.sv
// -----------------------------------------------------------------------------
// l2_cache_test
// Direct-mapped, write-through, no-write-allocate L2 cache controller.
// Read hits are answered from the line array; read misses fetch from memory
// and fill the line; every write goes to memory and updates the line only
// when it already holds that address.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : l2_cache_test_if.slave (L1 handshake + memory controls)
//   data_l1    : L1 data bus, driven here only while answering a read
//   mem_data   : memory data bus, driven here only during a write access
// -----------------------------------------------------------------------------
module l2_cache_test
  import l2_cache_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  l2_cache_test_if.slave    bus,
  inout  wire  [DATA_W-1:0] data_l1,
  inout  wire  [DATA_W-1:0] mem_data
);

  localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;

  l2_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              hit_q, hit_d;

  logic [INDEX_BITS-1:0] lineIdx;
  logic [TAG_W-1:0]      lineTag;
  logic                  lineValid;
  logic [TAG_W-1:0]      storedTag;
  logic [DATA_W-1:0]     storedData;
  logic                  lookupHit;
  logic                  arrWrEn;
  logic [DATA_W-1:0]     arrWrData;

  logic l1Ack;
  logic csN, rasN, casN, weN;
  logic l1Drive;
  logic memDrive;

  assign lineIdx   = INDEX_BITS'(get_index(addr_q, INDEX_BITS));
  assign lineTag   = TAG_W'(get_tag(addr_q, INDEX_BITS));
  assign lookupHit = lineValid && (storedTag == lineTag);
  // Writes store the L1 word; read fills store what memory returned.
  assign arrWrData = we_q ? wdata_q : mem_data;

  l2_tag_data_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx_i  (lineIdx),
    .rd_valid_o(lineValid),
    .rd_tag_o  (storedTag),
    .rd_data_o (storedData),
    .wr_en_i   (arrWrEn),
    .wr_idx_i  (lineIdx),
    .wr_tag_i  (lineTag),
    .wr_data_i (arrWrData)
  );

  // Request registers and FSM state; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      hit_q   <= hit_d;
    end
  end

  // Next-state and output decode. The request is held in registers from
  // IDLE onward, so mem_addr, we_n and write data stay stable across the
  // whole memory access. The hit result is remembered from LOOKUP because
  // a write needs it when memory completes.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    hit_d    = hit_q;
    arrWrEn  = 1'b0;
    l1Ack    = 1'b0;
    csN      = 1'b1;
    rasN     = 1'b1;
    casN     = 1'b1;
    weN      = 1'b1;
    l1Drive  = 1'b0;
    memDrive = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.stb) begin
          addr_d  = bus.addr_l1;
          we_d    = bus.we_in;
          wdata_d = data_l1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d   = lookupHit;
        state_d = (!we_q && lookupHit) ? RESPOND : MEM_RAS;
      end
      MEM_RAS: begin
        csN      = 1'b0;
        rasN     = 1'b0;
        weN      = ~we_q;
        memDrive = we_q;
        state_d  = MEM_CAS;
      end
      MEM_CAS: begin
        csN      = 1'b0;
        rasN     = 1'b0;
        casN     = 1'b0;
        weN      = ~we_q;
        memDrive = we_q;
        if (bus.stb_mem) begin
          arrWrEn = !we_q || hit_q;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        l1Ack   = 1'b1;
        l1Drive = !we_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.l1_ack   = l1Ack;
  assign bus.cs_n     = csN;
  assign bus.ras_n    = rasN;
  assign bus.cas_n    = casN;
  assign bus.we_n     = weN;
  assign bus.mem_addr = {addr_q[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  assign data_l1  = l1Drive  ? storedData : {DATA_W{1'bz}};
  assign mem_data = memDrive ? wdata_q    : {DATA_W{1'bz}};

endmodule

// File: tb/tb_l2_cache_test.sv
// -----------------------------------------------------------------------------
// tb_l2_cache_test
// Directed bench for the L2 cache controller. A transaction-level model
// (line array + main memory image) predicts hit/miss, latency and read data;
// a memory responder answers CAS cycles; a per-cycle compare process checks
// bus behaviour against the outstanding request.
// -----------------------------------------------------------------------------
module tb_l2_cache_test;

  localparam int INDEX_BITS = 6;
  localparam int LINES      = 1 << INDEX_BITS;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  l2_cache_test_if bus();

  wire  [63:0] data_l1;
  wire  [63:0] mem_data;
  logic        l1Drive;
  logic [63:0] l1Val;
  logic        memDrive;
  logic [63:0] memVal;

  assign data_l1  = l1Drive  ? l1Val  : 64'bz;
  assign mem_data = memDrive ? memVal : 64'bz;

  // Floating buses read back as all ones.
  pullup puL1 (data_l1);
  pullup puMem (mem_data);

  l2_cache_test #(.INDEX_BITS(INDEX_BITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .data_l1 (data_l1),
    .mem_data(mem_data)
  );

  int passCount;
  int checkCount;

  // Model state
  bit          mValid [LINES];
  int unsigned mTag   [LINES];
  logic [63:0] mData  [LINES];
  logic [63:0] modelMem [logic [31:0]];

  // Memory responder state
  logic [63:0] memStore [logic [31:0]];
  int          memDelay;
  int          memAccesses;
  int          casCycles;
  logic [31:0] memLastAddr;
  bit          memLastWe;
  logic [63:0] memLastData;

  // Outstanding request seen by the compare process
  bit          started;
  bit          reqActive;
  logic [31:0] reqAddr;
  bit          reqWe;
  logic [63:0] reqData;
  logic [63:0] expRd;
  bit          sawRas;

  logic [63:0] lastRd;
  int          lastLatency;

  function automatic logic [63:0] defaultWord(input logic [31:0] wa);
    return {wa, ~wa};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request (called at posedge+1), wait for the ack, check
  // latency and memory traffic against the model, then update the model.
  task automatic applyStimulus(input bit we, input logic [31:0] a, input logic [63:0] d);
    int unsigned idx;
    int unsigned tag;
    logic [31:0] wa;
    bit          hit;
    bit          acked;
    int          expLat;
    int          memBefore;
    int          cyc;

    wa  = a & ~32'h7;
    idx = (a / 8) % LINES;
    tag = a / (8 * LINES);
    hit = mValid[idx] && (mTag[idx] == tag);
    if (!we) begin
      if (hit)                   expRd = mData[idx];
      else if (modelMem.exists(wa)) expRd = modelMem[wa];
      else                       expRd = defaultWord(wa);
    end
    expLat = (!we && hit) ? 2 : 4 + memDelay;

    reqAddr   = a;
    reqWe     = we;
    reqData   = d;
    reqActive = 1'b1;
    memBefore = memAccesses;

    bus.stb     = 1'b1;
    bus.we_in   = we;
    bus.addr_l1 = a;
    l1Drive     = we;
    l1Val       = d;

    cyc   = 0;
    acked = 1'b0;
    while (!acked && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      acked = bus.l1_ack;
    end
    lastLatency = cyc;
    lastRd      = data_l1;
    bus.stb     = 1'b0;
    l1Drive     = 1'b0;

    checkOutput("ack_seen", 64'(acked), 64'd1);
    checkOutput("latency", 64'(cyc), 64'(expLat));
    checkOutput("mem_access_count", 64'(memAccesses - memBefore), (we || !hit) ? 64'd1 : 64'd0);

    if (we) begin
      modelMem[wa] = d;
      if (hit) mData[idx] = d;
    end else if (!hit) begin
      mValid[idx] = 1'b1;
      mTag[idx]   = tag;
      mData[idx]  = expRd;
    end

    @(posedge clk);
    #1;
    reqActive = 1'b0;
  endtask

  // Start a read miss, then assert reset while memory is still in CAS.
  task automatic resetDuringCas(input logic [31:0] a);
    int cyc;
    bit gotCas;

    memDelay    = 10;
    reqAddr     = a;
    reqWe       = 1'b0;
    reqData     = '0;
    reqActive   = 1'b1;
    bus.stb     = 1'b1;
    bus.we_in   = 1'b0;
    bus.addr_l1 = a;

    cyc    = 0;
    gotCas = 1'b0;
    while (!gotCas && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      gotCas = !bus.cas_n;
    end
    checkOutput("reached_cas", 64'(gotCas), 64'd1);

    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    bus.stb = 1'b0;
    #1;
    checkOutput("rst_ctrl_async",
                64'({bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n, bus.l1_ack}), 64'b11110);
    checkOutput("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    reqActive = 1'b0;
    rst_n     = 1'b1;
    memDelay  = 0;
    idleCycles(4);
  endtask

  // Memory responder: after memDelay CAS cycles, pulse stb_mem for one
  // cycle, storing write data or returning read data.
  initial begin
    bus.stb_mem = 1'b0;
    memDrive    = 1'b0;
    memVal      = '0;
    casCycles   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.stb_mem || !rst_n) begin
        bus.stb_mem = 1'b0;
        memDrive    = 1'b0;
        casCycles   = 0;
      end else if (!bus.cs_n && !bus.ras_n && !bus.cas_n) begin
        casCycles++;
        if (casCycles > memDelay) begin
          bus.stb_mem = 1'b1;
          memAccesses++;
          memLastAddr = bus.mem_addr;
          memLastWe   = !bus.we_n;
          if (!bus.we_n) begin
            memLastData = mem_data;
            memStore[bus.mem_addr] = mem_data;
          end else begin
            memLastData = memStore.exists(bus.mem_addr) ? memStore[bus.mem_addr]
                                                        : defaultWord(bus.mem_addr);
            memVal   = memLastData;
            memDrive = 1'b1;
          end
        end
      end else begin
        casCycles = 0;
      end
    end
  end

  // Per-cycle compare against the outstanding request.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      sawRas = 1'b0;
    end else if (started) begin
      if (!reqActive) begin
        checkOutput("idle_ctrl",
                    64'({bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n, bus.l1_ack}), 64'b11110);
      end else begin
        if (!bus.cs_n) begin
          checkOutput("mem_addr", 64'(bus.mem_addr), 64'(reqAddr & ~32'h7));
          checkOutput("mem_we_n", 64'(bus.we_n), 64'(!reqWe));
          checkOutput("mem_ras_n", 64'(bus.ras_n), 64'd0);
          if (!bus.cas_n) checkOutput("ras_before_cas", 64'(sawRas), 64'd1);
          if (reqWe) checkOutput("mem_wdata", mem_data, reqData);
        end
        if (bus.l1_ack && !reqWe) checkOutput("rd_data", data_l1, expRd);
      end
      if (!memDrive && !(reqActive && reqWe && !bus.cs_n))
        checkOutput("mem_bus_z", mem_data, ALL1);
      if (!l1Drive && !(reqActive && !reqWe && bus.l1_ack))
        checkOutput("l1_bus_z", data_l1, ALL1);
      if (bus.cs_n)                      sawRas = 1'b0;
      else if (!bus.ras_n && bus.cas_n)  sawRas = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    passCount   = 0;
    checkCount  = 0;
    started     = 1'b0;
    reqActive   = 1'b0;
    reqAddr     = '0;
    reqWe       = 1'b0;
    reqData     = '0;
    expRd       = '0;
    sawRas      = 1'b0;
    memDelay    = 0;
    memAccesses = 0;
    bus.stb     = 1'b0;
    bus.we_in   = 1'b0;
    bus.addr_l1 = '0;
    l1Drive     = 1'b0;
    l1Val       = '0;
    for (int i = 0; i < LINES; i++) begin
      mValid[i] = 1'b0;
      mTag[i]   = 0;
      mData[i]  = '0;
    end
    memStore[32'h0000_1008] = 64'h1122_3344_5566_7788;
    modelMem[32'h0000_1008] = 64'h1122_3344_5566_7788;

    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ctrl",
                64'({bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n, bus.l1_ack}), 64'b11110);
    checkOutput("reset_mem_addr", 64'(bus.mem_addr), 64'd0);
    checkOutput("reset_l1_bus_z", data_l1, ALL1);
    checkOutput("reset_mem_bus_z", mem_data, ALL1);
    rst_n   = 1'b1;
    started = 1'b1;
    idleCycles(5);
    checkOutput("no_access_without_stb", 64'(memAccesses), 64'd0);

    $display("[TB] read miss then hit at 0x1008");
    applyStimulus(1'b0, 32'h0000_1008, 64'h0);
    checkOutput("lit_miss_latency", 64'(lastLatency), 64'd4);
    checkOutput("lit_miss_data", lastRd, 64'h1122_3344_5566_7788);
    checkOutput("lit_miss_mem_addr", 64'(memLastAddr), 64'h1008);
    applyStimulus(1'b0, 32'h0000_1008, 64'h0);
    checkOutput("lit_hit_latency", 64'(lastLatency), 64'd2);
    checkOutput("lit_hit_data", lastRd, 64'h1122_3344_5566_7788);

    $display("[TB] write hit at 0x1008 with slow memory");
    memDelay = 2;
    applyStimulus(1'b1, 32'h0000_1008, 64'hDEAD_BEEF_0000_0001);
    checkOutput("lit_wr_latency", 64'(lastLatency), 64'd6);
    checkOutput("lit_wr_we", 64'(memLastWe), 64'd1);
    checkOutput("lit_wr_data", memLastData, 64'hDEAD_BEEF_0000_0001);
    memDelay = 0;
    applyStimulus(1'b0, 32'h0000_1008, 64'h0);
    checkOutput("lit_wr_hit_readback", lastRd, 64'hDEAD_BEEF_0000_0001);
    checkOutput("lit_wr_hit_rd_latency", 64'(lastLatency), 64'd2);

    $display("[TB] write miss at 0x2010 does not allocate");
    applyStimulus(1'b1, 32'h0000_2010, 64'hCAFE_F00D_1234_5678);
    checkOutput("lit_wr_miss_addr", 64'(memLastAddr), 64'h2010);
    applyStimulus(1'b0, 32'h0000_2010, 64'h0);
    checkOutput("lit_no_alloc_latency", 64'(lastLatency), 64'd4);
    checkOutput("lit_no_alloc_data", lastRd, 64'hCAFE_F00D_1234_5678);

    $display("[TB] index conflict 0x1008 / 0x1208");
    applyStimulus(1'b0, 32'h0000_1208, 64'h0);
    checkOutput("lit_conflict_latency", 64'(lastLatency), 64'd4);
    checkOutput("lit_conflict_data", lastRd, 64'h0000_1208_FFFF_EDF7);
    applyStimulus(1'b0, 32'h0000_1008, 64'h0);
    checkOutput("lit_evicted_latency", 64'(lastLatency), 64'd4);
    checkOutput("lit_evicted_data", lastRd, 64'hDEAD_BEEF_0000_0001);

    $display("[TB] reset during MEM_CAS of a read miss");
    resetDuringCas(32'h0000_3018);
    applyStimulus(1'b0, 32'h0000_3018, 64'h0);
    checkOutput("lit_after_reset_latency", 64'(lastLatency), 64'd4);
    checkOutput("lit_after_reset_data", lastRd, 64'h0000_3018_FFFF_CFE7);
    applyStimulus(1'b0, 32'h0000_3018, 64'h0);
    checkOutput("lit_after_reset_hit", 64'(lastLatency), 64'd2);
    applyStimulus(1'b0, 32'h0000_1008, 64'h0);
    checkOutput("lit_valid_cleared", 64'(lastLatency), 64'd4);

    idleCycles(3);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
